// File: rtl/bfp_frame_scaler_if.sv
// Streaming handshake bundle for bfp_frame_scaler: sample/index input side and
// normalized sample/exponent output side. master = environment, slave = scaler.
interface bfp_frame_scaler_if #(
  parameter int WIDTH     = 23,
  parameter int OUT_WIDTH = 16,
  parameter int IDX_W     = $clog2(WIDTH)
);
  logic [WIDTH-1:0]     in_data;
  logic [IDX_W-1:0]     in_index;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]     out_exp;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_index, in_valid, out_ready,
    input  in_ready, out_data, out_exp, out_last, out_valid
  );

  modport slave (
    input  in_data, in_index, in_valid, out_ready,
    output in_ready, out_data, out_exp, out_last, out_valid
  );
endinterface

// File: rtl/bfp_frame_scaler.sv
// Block-floating-point frame normalizer: buffers a frame, shifts it by one common
// exponent. Define BFP_ROUND_EN for round-half-up with positive saturation.
module bfp_frame_scaler #(
  parameter int WIDTH     = 23,
  parameter int OUT_WIDTH = 16,
  parameter int FRAME_LEN = 64,
  parameter int IDX_W     = $clog2(WIDTH)
) (
  input logic               clk,
  input logic               rst_n,
  bfp_frame_scaler_if.slave bus
);

  localparam int                CNT_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0]  TOP_IDX  = IDX_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam int                DROP     = WIDTH - OUT_WIDTH;

  typedef enum logic [1:0] {FILL, CALC, DRAIN} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [CNT_W-1:0]     r_wr_cnt;
  logic [CNT_W-1:0]     r_rd_cnt;
  logic [CNT_W-1:0]     w_rd_next;
  logic [IDX_W-1:0]     r_max_idx;
  logic [IDX_W-1:0]     r_exp;
  logic [IDX_W-1:0]     w_idx_clamped;
  logic [WIDTH-1:0]     r_buf [FRAME_LEN];
  logic [WIDTH-1:0]     r_rd_data;
  logic [WIDTH-1:0]     w_shifted;
  logic                 w_in_fire;
  logic                 w_out_fire;

  // Fire terms use the state directly so ready never feeds back into itself.
  assign w_in_fire     = bus.in_valid && (r_state == FILL);
  assign w_out_fire    = bus.out_ready && (r_state == DRAIN);
  assign w_rd_next     = r_rd_cnt + CNT_W'(1);
  assign w_idx_clamped = (bus.in_index > TOP_IDX) ? TOP_IDX : bus.in_index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, otherwise a path that
  // skips an assignment would infer a latch.
  always_comb begin
    w_next_state  = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    case (r_state)
      FILL: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && (r_wr_cnt == LAST_CNT)) w_next_state = CALC;
      end
      CALC: w_next_state = DRAIN;
      DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_last  = (r_rd_cnt == LAST_CNT);
        if (bus.out_ready && (r_rd_cnt == LAST_CNT)) w_next_state = FILL;
      end
      default: w_next_state = FILL;
    endcase
  end

  // NOTE: sample storage has no reset; only the control and output registers need
  // a known value, and leaving the array unreset lets it map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_in_fire) r_buf[r_wr_cnt] <= bus.in_data;
  end

  // NOTE: all state updates are non-blocking so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_max_idx <= '0;
      r_exp     <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_in_fire) begin
        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
        if ((r_wr_cnt == '0) || (w_idx_clamped > r_max_idx)) r_max_idx <= w_idx_clamped;
      end
      if (r_state == CALC) begin
        r_exp     <= TOP_IDX - r_max_idx;
        r_rd_data <= r_buf[0];
        r_rd_cnt  <= '0;
      end
      // Prefetch the next sample on each output handshake to keep drain bubble-free.
      if (w_out_fire) begin
        r_rd_cnt  <= w_rd_next;
        r_rd_data <= r_buf[w_rd_next];
        if (r_rd_cnt == LAST_CNT) r_max_idx <= '0;
      end
    end
  end

  assign w_shifted = r_rd_data <<< r_exp;

`ifdef BFP_ROUND_EN
  localparam int               RND_POS = (DROP > 0) ? DROP - 1 : 0;
  localparam logic [WIDTH:0]   RND_ADD = (DROP > 0) ? ((WIDTH + 1)'(1) << RND_POS) : '0;
  localparam logic [OUT_WIDTH-1:0] POS_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};

  logic [WIDTH:0] w_sum;
  logic           w_sat;

  // Only a positive value can carry past the top; negatives move toward zero.
  assign w_sum        = {w_shifted[WIDTH-1], w_shifted} + RND_ADD;
  assign w_sat        = !w_sum[WIDTH] && w_sum[WIDTH-1];
  assign bus.out_data = w_sat ? POS_MAX : OUT_WIDTH'(w_sum >> DROP);
`else
  assign bus.out_data = OUT_WIDTH'(w_shifted >> DROP);
`endif

  assign bus.out_exp = r_exp;

endmodule

// File: tb/tb_bfp_frame_scaler.sv
// Self-checking bench for bfp_frame_scaler: directed frames from known values plus
// random frames checked against an arithmetic block-floating-point model.
module tb_bfp_frame_scaler;

  localparam int W  = 23;
  localparam int OW = 16;
  localparam int FL = 4;
  localparam int IW = $clog2(W);

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [W-1:0]  f_data [FL];
  logic [IW-1:0] f_idx  [FL];
  logic [OW-1:0] e_data [FL];
  logic [IW-1:0] e_shift;

  bfp_frame_scaler_if #(.WIDTH(W), .OUT_WIDTH(OW), .IDX_W(IW)) bus ();

  bfp_frame_scaler #(.WIDTH(W), .OUT_WIDTH(OW), .FRAME_LEN(FL), .IDX_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Leading magnitude bit: highest 1 of a positive value, highest 0 of a negative one.
  function automatic logic [IW-1:0] detect_idx(input logic [W-1:0] x);
    logic [W-1:0] m;
    int r;
    m = x[W-1] ? ~x : x;
    r = 0;
    for (int i = 0; i < W; i++) if (m[i]) r = i;
    return IW'(r);
  endfunction

  // Reference: shift = (W-2) - max clamped index, then scale by 2^shift and
  // divide by 2^(W-OW) with floor (or round-half-up and saturate).
  task automatic build_expected();
    int mx;
    int c;
    longint v;
    mx = 0;
    for (int i = 0; i < FL; i++) begin
      c = (int'(f_idx[i]) > W - 2) ? W - 2 : int'(f_idx[i]);
      if (c > mx) mx = c;
    end
    e_shift = IW'(W - 2 - mx);
    for (int i = 0; i < FL; i++) begin
      v = longint'($signed(f_data[i])) * (longint'(1) << (W - 2 - mx));
`ifdef BFP_ROUND_EN
      v = (v + (longint'(1) << (W - OW - 1))) >>> (W - OW);
      if (v > (longint'(1) << (OW - 1)) - 1) v = (longint'(1) << (OW - 1)) - 1;
`else
      v = v >>> (W - OW);
`endif
      e_data[i] = v[OW-1:0];
    end
  endtask

  task automatic load_frame(input logic [W-1:0] d0, d1, d2, d3,
                            input logic [IW-1:0] i0, i1, i2, i3);
    f_data[0] = d0; f_data[1] = d1; f_data[2] = d2; f_data[3] = d3;
    f_idx[0]  = i0; f_idx[1]  = i1; f_idx[2]  = i2; f_idx[3]  = i3;
  endtask

  task automatic set_expect(input logic [IW-1:0] sh,
                            input logic [OW-1:0] o0, o1, o2, o3);
    e_shift = sh;
    e_data[0] = o0; e_data[1] = o1; e_data[2] = o2; e_data[3] = o3;
  endtask

  // Called at a negedge in FILL; returns at the negedge where out_valid should first be high.
  task automatic send_frame(input bit gaps);
    int cyc;
    for (int i = 0; i < FL; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      bus.in_data  = f_data[i];
      bus.in_index = f_idx[i];
      bus.in_valid = 1'b1;
      cyc = 0;
      while (bus.in_ready !== 1'b1 && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      if (cyc == 50) begin
        n_vec++; n_err++;
        $display("FAIL in_ready_timeout: sample %0d never accepted, in_ready=%b required 1", i, bus.in_ready);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL calc_cycle: {out_valid,in_ready}=%b required 00", {bus.out_valid, bus.in_ready});
    end
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL first_valid_latency: out_valid=%b required 1 two cycles after last accept", bus.out_valid);
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready. Modes 1/2 also
  // wiggle in_valid with junk, which must not be captured.
  task automatic drain(input string name, input int mode);
    int k;
    int cyc;
    bit have_held;
    logic [OW-1:0] held;
    logic [OW+IW:0] got;
    logic [OW+IW:0] want;
    k = 0; cyc = 0; have_held = 0; held = '0;
    while (k < FL && cyc < 200) begin
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 3 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode != 0) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = W'($urandom);
        bus.in_index = IW'($urandom_range(0, W - 2));
      end
      if (bus.out_valid === 1'b1) begin
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL %s_in_ready_drain: in_ready=%b required 0", name, bus.in_ready);
        end
        if (have_held) begin
          n_vec++;
          if (bus.out_data !== held) begin
            n_err++;
            $display("FAIL %s_hold: out_data=%h required %h while stalled", name, bus.out_data, held);
          end
        end
        if (bus.out_ready) begin
          got  = {bus.out_data, bus.out_exp, bus.out_last};
          want = {e_data[k], e_shift, 1'(k == FL - 1)};
          n_vec++;
          if (got !== want) begin
            n_err++;
            $display("FAIL %s_sample%0d: data/exp/last=%h/%0d/%b required %h/%0d/%b", name, k,
                     bus.out_data, bus.out_exp, bus.out_last, e_data[k], e_shift, (k == FL - 1));
          end
          k++;
          have_held = 0;
        end else begin
          held = bus.out_data;
          have_held = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_vec++;
    if (k < FL) begin
      n_err++;
      $display("FAIL %s_drain_timeout: %0d handshakes seen required %0d", name, k, FL);
    end else if ({bus.out_valid, bus.out_last, bus.in_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL %s_after_last: {out_valid,out_last,in_ready}=%b required 001", name,
               {bus.out_valid, bus.out_last, bus.in_ready});
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_vec++;
    if ({bus.in_ready, bus.out_valid, bus.out_last, bus.out_data, bus.out_exp} !==
        {1'b1, 1'b0, 1'b0, {OW{1'b0}}, {IW{1'b0}}}) begin
      n_err++;
      $display("FAIL %s: ready/valid/last/data/exp=%b/%b/%b/%h/%0d required 1/0/0/0000/0", name,
               bus.in_ready, bus.out_valid, bus.out_last, bus.out_data, bus.out_exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_index = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load_frame(23'd256, -23'sd3, 23'd5, 23'd0, 5'd8, 5'd1, 5'd2, 5'd0);
    set_expect(5'd13, 16'd16384, 16'hFF40, 16'd320, 16'd0);
    send_frame(0);
    drain("basic", 0);
  endtask

  task automatic test_full_scale();
    load_frame(23'h3FFFFF, 23'h400000, 23'd1, 23'd0, 5'd21, 5'd21, 5'd0, 5'd0);
    set_expect(5'd0, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000);
    send_frame(0);
    drain("full_scale", 0);
  endtask

  task automatic test_zero();
    load_frame(23'd0, 23'd0, 23'd0, 23'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    set_expect(5'd21, 16'd0, 16'd0, 16'd0, 16'd0);
    send_frame(0);
    drain("zero", 0);
  endtask

  task automatic test_clamp();
    load_frame(23'h3FFFFF, 23'd3, 23'h7FFFFF, 23'd0, 5'd31, 5'd1, 5'd0, 5'd0);
`ifdef BFP_ROUND_EN
    set_expect(5'd0, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
`else
    set_expect(5'd0, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h0000);
`endif
    send_frame(0);
    drain("clamp", 0);
  endtask

  task automatic test_rounding();
    load_frame(23'h2000C0, 23'h3FFFFF, 23'd0, 23'd0, 5'd21, 5'd21, 5'd0, 5'd0);
`ifdef BFP_ROUND_EN
    set_expect(5'd0, 16'h4002, 16'h7FFF, 16'h0000, 16'h0000);
`else
    set_expect(5'd0, 16'h4001, 16'h7FFF, 16'h0000, 16'h0000);
`endif
    send_frame(0);
    drain("rounding", 0);
  endtask

  task automatic test_backpressure();
    load_frame(23'd256, -23'sd3, 23'd5, 23'd0, 5'd8, 5'd1, 5'd2, 5'd0);
    set_expect(5'd13, 16'd16384, 16'hFF40, 16'd320, 16'd0);
    send_frame(0);
    drain("backpressure", 1);
    // A following frame confirms junk offered during drain was never written.
    test_basic();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      bus.in_data = 23'h3FFFFF; bus.in_index = 5'd21; bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_fill");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();

    load_frame(23'h3FFFFF, 23'd1, 23'd0, 23'd0, 5'd21, 5'd0, 5'd0, 5'd0);
    send_frame(0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_drain");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_zero();
  endtask

  task automatic test_random();
    logic [31:0] raw;
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < FL; i++) begin
        raw = $urandom;
        f_data[i] = W'($signed(raw[W-1:0]) >>> $urandom_range(0, W - 1));
        f_idx[i]  = detect_idx(f_data[i]);
        if (f_idx[i] == IW'(W - 2) && $urandom_range(0, 3) == 0)
          f_idx[i] = IW'($urandom_range(W - 1, (1 << IW) - 1));
      end
      build_expected();
      send_frame(1);
      drain("random", 2);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_full_scale();
    test_zero();
    test_clamp();
    test_rounding();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
